// File: rtl/rat_intr_pkg.sv
// Shared definitions for the RAT interrupt controller: register offsets,
// vector layout and the priority-encoder helper.
package rat_intr_pkg;

    typedef logic [7:0] port_data_t;

    localparam logic [1:0] OFS_MASK = 2'd0;
    localparam logic [1:0] OFS_PEND = 2'd1;
    localparam logic [1:0] OFS_EDGE = 2'd2;
    localparam logic [1:0] OFS_VEC  = 2'd3;

    localparam int unsigned VEC_VALID_BIT = 7;

    // Index of the lowest set bit; source 0 has the highest priority.
    function automatic logic [2:0] lowest_set(input port_data_t v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = i[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rat_intr_ctrl_sync.sv
// Per-source request conditioning: two-flop synchroniser plus an edge-history
// flop that always tracks the synchronised level.
module irq_sync_edge (
    input  logic clk,
    input  logic RESET_N,
    input  logic irq_async,
    input  logic edge_mode,
    output logic s,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Two-stage synchroniser for the asynchronous request.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= irq_async;
            sync_q <= meta_q;
        end
    end

    // History flop follows s in both modes so a mode switch cannot fake an edge.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_q;
        end
    end

    assign s    = sync_q;
    assign rise = edge_mode & sync_q & ~hist_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller feeding the RAT MCU INTV input. Registers are written
// over the MCU output port and read combinationally for the IN_PORT mux.
module rat_intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter int unsigned N_SRC   = 8,
    parameter logic [7:0]  BASE_ID = 8'h20
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic [7:0]       RD_DATA,
    output logic             RD_HIT,
    output logic             INTV
);

    logic [7:0]       ofs;
    logic             hit;
    logic             wr_en;
    logic [N_SRC-1:0] wdata;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] edge_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] s_vec;
    logic [N_SRC-1:0] rise_vec;
    logic             intv_q;
    port_data_t       mask_ext;
    port_data_t       pend_ext;
    port_data_t       edge_ext;
    port_data_t       enabled;
    port_data_t       vec_val;

    assign ofs      = PORT_ID - BASE_ID;
    assign hit      = (ofs[7:2] == 6'd0);
    assign wr_en    = IO_STRB & hit;
    assign wdata    = OUT_PORT[N_SRC-1:0];
    assign pend_clr = (wr_en && (ofs[1:0] == OFS_PEND)) ? wdata : '0;

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_src
            irq_sync_edge u_sync (
                .clk       (clk),
                .RESET_N   (RESET_N),
                .irq_async (IRQ_IN[g]),
                .edge_mode (edge_q[g]),
                .s         (s_vec[g]),
                .rise      (rise_vec[g])
            );
        end
    endgenerate

    // MASK and EDGE registers; writes are plain loads so repeated strobes are harmless.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_q <= '0;
            edge_q <= '1;
        end else if (wr_en) begin
            case (ofs[1:0])
                OFS_MASK: mask_q <= wdata;
                OFS_EDGE: edge_q <= wdata;
                default: ;
            endcase
        end
    end

    // Pending latch: edge sources set on rise (set beats W1C), level sources follow s.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (edge_q[i]) begin
                    if (rise_vec[i]) begin
                        pend_q[i] <= 1'b1;
                    end else if (pend_clr[i]) begin
                        pend_q[i] <= 1'b0;
                    end
                end else begin
                    pend_q[i] <= s_vec[i];
                end
            end
        end
    end

    // Registered interrupt request to the MCU.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            intv_q <= 1'b0;
        end else begin
            intv_q <= |(pend_q & mask_q);
        end
    end

    assign INTV = intv_q;

    // Zero-extend the registers to port width and build the vector register.
    always_comb begin
        mask_ext             = '0;
        pend_ext             = '0;
        edge_ext             = '0;
        mask_ext[N_SRC-1:0]  = mask_q;
        pend_ext[N_SRC-1:0]  = pend_q;
        edge_ext[N_SRC-1:0]  = edge_q;
        enabled              = pend_ext & mask_ext;
        vec_val              = '0;
        if (|enabled) begin
            vec_val[VEC_VALID_BIT] = 1'b1;
            vec_val[2:0]           = lowest_set(enabled);
        end
    end

    // Combinational read mux so an IN instruction sees data in its execute cycle.
    always_comb begin
        RD_DATA = '0;
        RD_HIT  = hit;
        if (hit) begin
            case (ofs[1:0])
                OFS_MASK: RD_DATA = mask_ext;
                OFS_PEND: RD_DATA = pend_ext;
                OFS_EDGE: RD_DATA = edge_ext;
                OFS_VEC:  RD_DATA = vec_val;
                default:  RD_DATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed self-checking bench for rat_intr_ctrl.
module tb_rat_intr_ctrl;

    localparam logic [7:0] BASE = 8'h20;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [7:0] IRQ_IN;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] RD_DATA;
    logic       RD_HIT;
    logic       INTV;

    int checks = 0;
    int errors = 0;

    rat_intr_ctrl #(.N_SRC(8), .BASE_ID(8'h20)) dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .IRQ_IN   (IRQ_IN),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .RD_DATA  (RD_DATA),
        .RD_HIT   (RD_HIT),
        .INTV     (INTV)
    );

    always #10 clk = ~clk;

    // Combinational register read, sampled 1ns after driving PORT_ID.
    task automatic read_reg(input logic [1:0] ofs, output logic [7:0] d);
        PORT_ID = BASE + {6'd0, ofs};
        #1;
        d = RD_DATA;
    endtask

    // One strobed write; returns at the negedge after the write edge.
    task automatic write_reg(input logic [1:0] ofs, input logic [7:0] v);
        @(negedge clk);
        PORT_ID  = BASE + {6'd0, ofs};
        OUT_PORT = v;
        IO_STRB  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        IO_STRB  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        RESET_N  = 1'b0;
        IRQ_IN   = '0;
        PORT_ID  = '0;
        OUT_PORT = '0;
        IO_STRB  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RESET_N = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read_reg(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mask: got %02h expected 00", d); end
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_pend: got %02h expected 00", d); end
        read_reg(2'd2, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reset_edge: got %02h expected ff", d); end
        read_reg(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_vec: got %02h expected 00", d); end
        checks++; if (RD_HIT !== 1'b1) begin errors++; $display("FAIL hit_23: got %0b expected 1", RD_HIT); end
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL reset_intv: got %0b expected 0", INTV); end
        PORT_ID = 8'h24; #1;
        checks++; if (RD_HIT !== 1'b0) begin errors++; $display("FAIL hit_24: got %0b expected 0", RD_HIT); end
        checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL miss_data_24: got %02h expected 00", RD_DATA); end
        PORT_ID = 8'h1F; #1;
        checks++; if (RD_HIT !== 1'b0) begin errors++; $display("FAIL hit_1f: got %0b expected 0", RD_HIT); end
    endtask

    task automatic test_edge_single();
        logic [7:0] d;
        write_reg(2'd0, 8'h04);
        IRQ_IN[2] = 1'b1;
        @(posedge clk);              // edge 1
        @(negedge clk);
        IRQ_IN[2] = 1'b0;
        @(posedge clk);              // edge 2
        @(posedge clk);              // edge 3
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL e1_pend_edge3: got %02h expected 04", d); end
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL e1_intv_edge3: got %0b expected 0", INTV); end
        @(posedge clk);              // edge 4
        @(negedge clk);
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL e1_intv_edge4: got %0b expected 1", INTV); end
        read_reg(2'd3, d);
        checks++; if (d !== 8'h82) begin errors++; $display("FAIL e1_vec: got %02h expected 82", d); end
        write_reg(2'd1, 8'h04);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL e1_pend_w1c: got %02h expected 00", d); end
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL e1_intv_at_w1c: got %0b expected 1", INTV); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL e1_intv_after_w1c: got %0b expected 0", INTV); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        write_reg(2'd0, 8'hFF);
        IRQ_IN = 8'h22;
        @(posedge clk);
        @(negedge clk);
        IRQ_IN = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        read_reg(2'd3, d);
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL pri_vec_both: got %02h expected 81", d); end
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL pri_intv_both: got %0b expected 1", INTV); end
        write_reg(2'd1, 8'h02);
        read_reg(2'd3, d);
        checks++; if (d !== 8'h85) begin errors++; $display("FAIL pri_vec_src5: got %02h expected 85", d); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL pri_intv_stays: got %0b expected 1", INTV); end
        write_reg(2'd1, 8'h20);
        read_reg(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL pri_vec_none: got %02h expected 00", d); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL pri_intv_falls: got %0b expected 0", INTV); end
    endtask

    task automatic test_set_beats_clear();
        logic [7:0] d;
        @(negedge clk);
        IRQ_IN[3] = 1'b1;
        @(posedge clk);              // edge 1
        @(negedge clk);
        IRQ_IN[3] = 1'b0;
        @(posedge clk);              // edge 2: rise now high
        write_reg(2'd1, 8'h08);      // write lands on edge 3 with the rise
        read_reg(2'd1, d);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL sbc_pend: got %02h expected 08", d); end
        write_reg(2'd1, 8'h08);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL sbc_pend_cleanup: got %02h expected 00", d); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_level();
        logic [7:0] d;
        write_reg(2'd2, 8'hFE);
        write_reg(2'd0, 8'h01);
        IRQ_IN[0] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL lvl_pend_set: got %02h expected 01", d); end
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL lvl_intv_set: got %0b expected 1", INTV); end
        write_reg(2'd1, 8'h01);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL lvl_w1c_ignored: got %02h expected 01", d); end
        @(negedge clk);
        IRQ_IN[0] = 1'b0;
        @(posedge clk);              // edge 1
        @(posedge clk);              // edge 2
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL lvl_pend_edge2: got %02h expected 01", d); end
        @(posedge clk);              // edge 3
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL lvl_pend_edge3: got %02h expected 00", d); end
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL lvl_intv_edge3: got %0b expected 1", INTV); end
        @(posedge clk);              // edge 4
        @(negedge clk);
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL lvl_intv_edge4: got %0b expected 0", INTV); end
        write_reg(2'd2, 8'hFF);
    endtask

    task automatic test_mask_and_reset();
        logic [7:0] d;
        write_reg(2'd0, 8'h00);
        IRQ_IN[4] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL msk_pend: got %02h expected 10", d); end
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL msk_intv_masked: got %0b expected 0", INTV); end
        write_reg(2'd0, 8'h10);
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL msk_intv_at_write: got %0b expected 0", INTV); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (INTV !== 1'b1) begin errors++; $display("FAIL msk_intv_unmask: got %0b expected 1", INTV); end
        write_reg(2'd2, 8'h0F);
        // Asynchronous reset mid-run, applied away from any clock edge.
        #3;
        RESET_N = 1'b0;
        #1;
        checks++; if (INTV !== 1'b0) begin errors++; $display("FAIL rst_intv: got %0b expected 0", INTV); end
        read_reg(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mask: got %02h expected 00", d); end
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_pend: got %02h expected 00", d); end
        read_reg(2'd2, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rst_edge: got %02h expected ff", d); end
        read_reg(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_vec: got %02h expected 00", d); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET_N = 1'b1;              // IRQ_IN[4] still high across release
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rel_pend_edge2: got %02h expected 00", d); end
        @(posedge clk);
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL rel_pend_edge3: got %02h expected 10", d); end
        write_reg(2'd1, 8'h10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        read_reg(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rel_no_new_edge: got %02h expected 00", d); end
        IRQ_IN = '0;
    endtask

    initial begin
        test_reset();
        test_edge_single();
        test_priority();
        test_set_beats_clear();
        test_level();
        test_mask_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
